// File: rtl/frame_stream_tx.sv
// frame_stream_tx: replays a stored frame onto a parallel camera bus (PCLK/VS/HS/D).
// Define TEST_PATTERN_EN to add i_Pattern_Sel and a synthetic diagonal ramp source.
module frame_stream_tx #(
    parameter int H_ACTIVE     = 96,
    parameter int V_ACTIVE     = 96,
    parameter int H_BLANK      = 8,
    parameter int V_SYNC_LINES = 2,
    parameter int CLK_DIV      = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Enable,
    input  logic [7:0]  i_RAM_Data,
`ifdef TEST_PATTERN_EN
    input  logic        i_Pattern_Sel,
`endif
    output logic [14:0] o_RAM_Adress,
    output logic        o_PCLK,
    output logic        o_VS,
    output logic        o_HS,
    output logic [7:0]  o_D,
    output logic        o_Frame_Done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_SYNC_LINES + V_ACTIVE;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] PIX_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] BLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(V_SYNC_LINES - 1);
    localparam logic [15:0] LINE_LAST  = 16'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        VSYNC,
        LINE_BLANK,
        LINE_ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic        pclk_q, pclk_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] line_q, line_d;
    logic [14:0] addr_q, addr_d;
    logic        vs_q, vs_d;
    logic        hs_q, hs_d;
    logic [7:0]  d_q, d_d;
    logic        done_q, done_d;

    logic        div_wrap;
    logic        fall_tick;
    logic        pix_wrap;
    logic [15:0] pix_inc;
    logic [7:0]  pix_src;

`ifdef TEST_PATTERN_EN
    logic       pat_q, pat_d;
    logic       use_pat;
    logic [7:0] act_idx;
    logic [7:0] line_idx;

    // Pattern select is latched at line start so a line never mixes sources
    always_comb begin
        act_idx  = (state_q == LINE_BLANK) ? 8'd0
                                           : pix_q[7:0] + 8'd1 - 8'(H_BLANK);
        line_idx = line_q[7:0] - 8'(V_SYNC_LINES);
        use_pat  = (state_q == LINE_BLANK) ? i_Pattern_Sel : pat_q;
        pat_d    = pat_q;
        if (fall_tick && state_q == LINE_BLANK && pix_q == BLANK_LAST)
            pat_d = i_Pattern_Sel;
        pix_src  = use_pat ? (act_idx + line_idx) : i_RAM_Data;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) pat_q <= 1'b0;
        else          pat_q <= pat_d;
    end
`else
    assign pix_src = i_RAM_Data;
`endif

    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        div_d     = div_wrap ? 16'd0 : div_q + 16'd1;
        pclk_d    = div_wrap ? ~pclk_q : pclk_q;
        fall_tick = div_wrap & pclk_q;
        pix_wrap  = (pix_q == PIX_LAST);
        pix_inc   = pix_wrap ? 16'd0 : pix_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        line_d  = line_q;
        addr_d  = addr_q;
        vs_d    = vs_q;
        hs_d    = hs_q;
        d_d     = d_q;
        done_d  = 1'b0;
        if (fall_tick) begin
            unique case (state_q)
                IDLE: begin
                    vs_d = 1'b1;
                    hs_d = 1'b0;
                    if (i_Enable) begin
                        state_d = VSYNC;
                        pix_d   = 16'd0;
                        line_d  = 16'd0;
                        addr_d  = 15'd0;
                    end
                end
                VSYNC: begin
                    pix_d = pix_inc;
                    if (pix_wrap) begin
                        line_d = line_q + 16'd1;
                        if (line_q == SYNC_LAST) begin
                            state_d = LINE_BLANK;
                            vs_d    = 1'b0;
                        end
                    end
                end
                LINE_BLANK: begin
                    pix_d = pix_q + 16'd1;
                    if (pix_q == BLANK_LAST) begin
                        state_d = LINE_ACTIVE;
                        hs_d    = 1'b1;
                        d_d     = pix_src;
                        addr_d  = addr_q + 15'd1;
                    end
                end
                LINE_ACTIVE: begin
                    pix_d = pix_inc;
                    if (!pix_wrap) begin
                        d_d    = pix_src;
                        addr_d = addr_q + 15'd1;
                    end else if (line_q != LINE_LAST) begin
                        state_d = LINE_BLANK;
                        hs_d    = 1'b0;
                        line_d  = line_q + 16'd1;
                    end else begin
                        // Frame boundary: enable decides between replay and idle
                        hs_d    = 1'b0;
                        vs_d    = 1'b1;
                        done_d  = 1'b1;
                        line_d  = 16'd0;
                        state_d = i_Enable ? VSYNC : IDLE;
                        if (i_Enable) addr_d = 15'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            div_q   <= 16'd0;
            pclk_q  <= 1'b0;
            pix_q   <= 16'd0;
            line_q  <= 16'd0;
            addr_q  <= 15'd0;
            vs_q    <= 1'b1;
            hs_q    <= 1'b0;
            d_q     <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign o_RAM_Adress = addr_q;
    assign o_PCLK       = pclk_q;
    assign o_VS         = vs_q;
    assign o_HS         = hs_q;
    assign o_D          = d_q;
    assign o_Frame_Done = done_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// tb_frame_stream_tx: randomized frame replay checked against a queue-based bus model.
// Small geometry keeps each frame around a thousand cycles.
module tb_frame_stream_tx;

    localparam int HA   = 16;
    localparam int VA   = 12;
    localparam int HB   = 3;
    localparam int VSL  = 2;
    localparam int CD   = 2;
    localparam int NPIX = HA * VA;
    localparam int LINE_CYC  = (HA + HB) * 2 * CD;
    localparam int FRAME_CYC = (VSL + VA) * LINE_CYC;
    localparam int VS_CYC    = VSL * LINE_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  ram_q;
    logic [14:0] addr;
    logic        pclk, vs, hs, done;
    logic [7:0]  d;
`ifdef TEST_PATTERN_EN
    logic        pat_sel = 1'b0;
`endif

    logic [7:0] mem [0:32767];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ram_q <= mem[addr];

    frame_stream_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .V_SYNC_LINES(VSL), .CLK_DIV(CD)
    ) dut (
        .i_Clk(clk),
        .i_Rst_n(rst_n),
        .i_Enable(en),
        .i_RAM_Data(ram_q),
`ifdef TEST_PATTERN_EN
        .i_Pattern_Sel(pat_sel),
`endif
        .o_RAM_Adress(addr),
        .o_PCLK(pclk),
        .o_VS(vs),
        .o_HS(hs),
        .o_D(d),
        .o_Frame_Done(done)
    );

    // Bus monitor: what a capture receiver would see at PCLK rising edges
    int cyc = 0, done_cnt = 0, cur_len = 0, hs_cnt = 0, vs_rise_t = 0;
    int done_t[$];
    int vs_hi[$];
    int line_len[$];
    logic [7:0] got[$];
    logic pclk_p = 1'b0, vs_p = 1'b1, hs_p = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_t.push_back(cyc);
        end
        if (vs === 1'b1 && vs_p !== 1'b1) vs_rise_t = cyc;
        if (vs === 1'b0 && vs_p === 1'b1) vs_hi.push_back(cyc - vs_rise_t);
        if (pclk === 1'b1 && pclk_p === 1'b0 && hs === 1'b1) begin
            got.push_back(d);
            cur_len++;
        end
        if (hs === 1'b1) hs_cnt++;
        if (hs !== 1'b1 && hs_p === 1'b1) begin
            line_len.push_back(cur_len);
            cur_len = 0;
        end
        pclk_p = pclk;
        vs_p   = vs;
        hs_p   = hs;
    end

    int g0, l0, d0, dt0, v0, h0;

    task automatic mark();
        g0  = got.size();
        l0  = line_len.size();
        d0  = done_cnt;
        dt0 = done_t.size();
        v0  = vs_hi.size();
        h0  = hs_cnt;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    endtask

    task automatic wait_done(input int n, input string tag);
        int t = 0;
        while (done_cnt - d0 < n && t < 3 * FRAME_CYC) begin
            step();
            t++;
        end
        total++;
        if (done_cnt - d0 < n) begin
            bad++;
            $display("FAIL %s timeout: frame_done count %0d, required %0d",
                     tag, done_cnt - d0, n);
        end
    endtask

    task automatic wait_vs_low(input string tag);
        int t = 0;
        while (vs !== 1'b0 && t < 3 * FRAME_CYC) begin
            step();
            t++;
        end
        total++;
        if (vs !== 1'b0) begin
            bad++;
            $display("FAIL %s timeout: vs %b, required 0", tag, vs);
        end
    endtask

    task automatic test_reset();
        int toggles = 0, spacing_bad = 0, busy = 0, last = -1;
        logic pp;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();
        total += 6;
        if (vs !== 1'b1)    begin bad++; $display("FAIL rst_vs got %b want 1", vs); end
        if (hs !== 1'b0)    begin bad++; $display("FAIL rst_hs got %b want 0", hs); end
        if (d !== 8'd0)     begin bad++; $display("FAIL rst_d got %0d want 0", d); end
        if (addr !== 15'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", addr); end
        if (pclk !== 1'b0)  begin bad++; $display("FAIL rst_pclk got %b want 0", pclk); end
        if (done !== 1'b0)  begin bad++; $display("FAIL rst_done got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        mark();
        pp = pclk;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (pclk !== pp) begin
                if (last >= 0 && i - last != CD) spacing_bad++;
                last = i;
                toggles++;
                pp = pclk;
            end
            if (vs !== 1'b1 || addr !== 15'd0 || d !== 8'd0) busy++;
        end
        total += 4;
        if (toggles != 1000 / CD) begin
            bad++; $display("FAIL idle_pclk_toggles got %0d want %0d", toggles, 1000 / CD);
        end
        if (spacing_bad != 0) begin
            bad++; $display("FAIL idle_pclk_spacing got %0d bad gaps want 0", spacing_bad);
        end
        if (hs_cnt != h0) begin
            bad++; $display("FAIL idle_hs got %0d high cycles want 0", hs_cnt - h0);
        end
        if (busy != 0) begin
            bad++; $display("FAIL idle_outputs got %0d disturbed cycles want 0", busy);
        end
    endtask

    task automatic test_single_frame();
        int errs = 0;
        fill_mem();
        mark();
        en = 1'b1;
        wait_vs_low("single_vs");
        en = 1'b0;
        wait_done(1, "single_done");
        total += 3;
        if (addr !== 15'(NPIX)) begin
            bad++; $display("FAIL single_addr got %0d want %0d", addr, NPIX);
        end
        if (line_len.size() - l0 != VA) begin
            bad++; $display("FAIL single_lines got %0d want %0d", line_len.size() - l0, VA);
        end
        if (got.size() - g0 != NPIX) begin
            bad++; $display("FAIL single_pixels got %0d want %0d", got.size() - g0, NPIX);
        end
        for (int l = l0; l < line_len.size(); l++) begin
            total++;
            if (line_len[l] != HA) begin
                bad++; $display("FAIL single_linelen line %0d got %0d want %0d", l - l0, line_len[l], HA);
            end
        end
        if (got.size() - g0 == NPIX) begin
            for (int i = 0; i < NPIX; i++) begin
                total++;
                if (got[g0 + i] !== mem[i]) begin
                    bad++; errs++;
                    if (errs < 8)
                        $display("FAIL single_data pix %0d got %0d want %0d", i, got[g0 + i], mem[i]);
                end
            end
        end
        h0 = hs_cnt;
        repeat (3 * LINE_CYC) step();
        total += 3;
        if (hs_cnt != h0) begin
            bad++; $display("FAIL single_idle_hs got %0d high cycles want 0", hs_cnt - h0);
        end
        if (vs !== 1'b1) begin bad++; $display("FAIL single_idle_vs got %b want 1", vs); end
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_continuous();
        int errs = 0;
        fill_mem();
        mark();
        en = 1'b1;
        wait_done(1, "cont_first");
        mark();
        wait_done(2, "cont_more");
        total += 2;
        if (done_t.size() - dt0 >= 2 && done_t[dt0 + 1] - done_t[dt0] != FRAME_CYC) begin
            bad++; $display("FAIL cont_period got %0d want %0d", done_t[dt0 + 1] - done_t[dt0], FRAME_CYC);
        end else if (done_t.size() - dt0 < 2) begin
            bad++; $display("FAIL cont_period got %0d pulses want 2", done_t.size() - dt0);
        end
        if (vs_hi.size() - v0 < 1 || vs_hi[v0] != VS_CYC) begin
            bad++;
            $display("FAIL cont_vs_width got %0d want %0d",
                     (vs_hi.size() > v0) ? vs_hi[v0] : -1, VS_CYC);
        end
        total++;
        if (got.size() - g0 != 2 * NPIX) begin
            bad++; $display("FAIL cont_pixels got %0d want %0d", got.size() - g0, 2 * NPIX);
        end else begin
            for (int i = 0; i < 2 * NPIX; i++) begin
                total++;
                if (got[g0 + i] !== mem[i % NPIX]) begin
                    bad++; errs++;
                    if (errs < 8)
                        $display("FAIL cont_data pix %0d got %0d want %0d", i, got[g0 + i], mem[i % NPIX]);
                end
            end
        end
        en = 1'b0;
        mark();
        wait_done(1, "cont_stop");
    endtask

    task automatic test_enable_drop();
        int drop_line, t = 0;
        drop_line = $urandom_range(VA - 2, 1);
        fill_mem();
        mark();
        en = 1'b1;
        while (line_len.size() - l0 < drop_line && t < 3 * FRAME_CYC) begin
            step();
            t++;
        end
        en = 1'b0;
        wait_done(1, "drop_done");
        total += 2;
        if (line_len.size() - l0 != VA) begin
            bad++; $display("FAIL drop_lines got %0d want %0d", line_len.size() - l0, VA);
        end
        if (got.size() - g0 != NPIX) begin
            bad++; $display("FAIL drop_pixels got %0d want %0d", got.size() - g0, NPIX);
        end
        h0 = hs_cnt;
        repeat (FRAME_CYC + LINE_CYC) step();
        total += 3;
        if (hs_cnt != h0) begin
            bad++; $display("FAIL drop_idle_hs got %0d high cycles want 0", hs_cnt - h0);
        end
        if (vs !== 1'b1) begin bad++; $display("FAIL drop_idle_vs got %b want 1", vs); end
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL drop_done_count got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reassert();
        int t = 0;
        mark();
        en = 1'b1;
        wait_vs_low("reas_vs");
        en = 1'b0;
        while (line_len.size() - l0 < VA - 1 && t < 3 * FRAME_CYC) begin
            step();
            t++;
        end
        repeat (LINE_CYC / 2) step();
        en = 1'b1;
        wait_done(2, "reas_done");
        total++;
        if (done_t.size() - dt0 < 2 || done_t[dt0 + 1] - done_t[dt0] != FRAME_CYC) begin
            bad++;
            $display("FAIL reas_period got %0d want %0d",
                     (done_t.size() - dt0 >= 2) ? done_t[dt0 + 1] - done_t[dt0] : -1, FRAME_CYC);
        end
        en = 1'b0;
        mark();
        wait_done(1, "reas_stop");
    endtask

    task automatic test_reset_mid();
        int rl, rp, t = 0, errs = 0;
        rl = $urandom_range(VA - 2, 1);
        rp = $urandom_range(HA - 2, 1);
        fill_mem();
        mark();
        en = 1'b1;
        while (!(line_len.size() - l0 == rl && cur_len == rp) && t < 3 * FRAME_CYC) begin
            step();
            t++;
        end
        rst_n = 1'b0;
        #1;
        total += 5;
        if (vs !== 1'b1)    begin bad++; $display("FAIL mid_rst_vs got %b want 1", vs); end
        if (hs !== 1'b0)    begin bad++; $display("FAIL mid_rst_hs got %b want 0", hs); end
        if (d !== 8'd0)     begin bad++; $display("FAIL mid_rst_d got %0d want 0", d); end
        if (addr !== 15'd0) begin bad++; $display("FAIL mid_rst_addr got %0d want 0", addr); end
        if (pclk !== 1'b0)  begin bad++; $display("FAIL mid_rst_pclk got %b want 0", pclk); end
        repeat (4) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mark();
        wait_vs_low("mid_vs");
        en = 1'b0;
        wait_done(1, "mid_done");
        total++;
        if (got.size() - g0 != NPIX) begin
            bad++; $display("FAIL mid_pixels got %0d want %0d", got.size() - g0, NPIX);
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                total++;
                if (got[g0 + i] !== mem[i]) begin
                    bad++; errs++;
                    if (errs < 8)
                        $display("FAIL mid_data pix %0d got %0d want %0d", i, got[g0 + i], mem[i]);
                end
            end
        end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        int errs = 0;
        fill_mem();
        pat_sel = 1'b1;
        mark();
        en = 1'b1;
        wait_vs_low("pat_vs");
        en = 1'b0;
        wait_done(1, "pat_done");
        total++;
        if (got.size() - g0 != NPIX) begin
            bad++; $display("FAIL pat_pixels got %0d want %0d", got.size() - g0, NPIX);
        end else begin
            for (int l = 0; l < VA; l++) begin
                for (int p = 0; p < HA; p++) begin
                    total++;
                    if (got[g0 + l * HA + p] !== 8'((l + p) % 256)) begin
                        bad++; errs++;
                        if (errs < 8)
                            $display("FAIL pat_data line %0d pix %0d got %0d want %0d",
                                     l, p, got[g0 + l * HA + p], (l + p) % 256);
                    end
                end
            end
        end
        pat_sel = 1'b0;
    endtask
`endif

    initial begin
        fill_mem();
        test_reset();
        test_single_frame();
        test_continuous();
        test_enable_drop();
        test_reassert();
        test_reset_mid();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_stream_tx.md
Name: frame_stream_tx

Overview:
- Camera-side transmitter. Reads a stored frame from the 8-bit frame RAM and drives a parallel camera bus: pixel clock, VS, HS and 8-bit data.
- Timing matches the capture path: VS high during frame blanking, HS high during valid pixels, data sampled on PCLK rising edge.
- Used as a loopback/emulation source for capture and RAM verification without a physical sensor, and as a replay source for processed frames.

Parameters:
- H_ACTIVE, 96, valid pixels per line.
- V_ACTIVE, 96, valid lines per frame (H_ACTIVE*V_ACTIVE must be ≤ 32768).
- H_BLANK, 8, blank pixel periods per line (HS low); must be ≥ 1.
- V_SYNC_LINES, 2, line periods with VS high at frame start; must be ≥ 1.
- CLK_DIV, 2, i_Clk cycles per PCLK half-period; must be ≥ 1.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Enable  in  1  level; frames stream while high.
- i_RAM_Data  in  8  RAM read data; 1 i_Clk read latency.
- o_RAM_Adress  out  15  RAM read address.
- o_PCLK  out  1  generated pixel clock.
- o_VS  out  1  vertical sync; high = blanking/reset.
- o_HS  out  1  horizontal valid; high = pixel data valid.
- o_D  out  8  pixel data.
- o_Frame_Done  out  1  one-i_Clk pulse at the end of the last active pixel of a frame.
- i_Pattern_Sel  in  1  present only with TEST_PATTERN_EN.

Behaviour:
- Reset values (asynchronous): o_PCLK=0, o_VS=1, o_HS=0, o_D=0, o_RAM_Adress=0, o_Frame_Done=0, state=IDLE, all counters 0.
- Clock divider:
  - Counts 0..CLK_DIV-1 and toggles o_PCLK at the wrap; free-runs after reset.
  - Toggle 1→0 = "fall tick". All bus outputs (VS, HS, D) change only on fall ticks, one i_Clk after the divider wrap, so they are stable across PCLK rising edges.
  - Pixel period = 2*CLK_DIV i_Clk cycles.
- Counters, both advanced on fall ticks:
  - pix_cnt: 0..H_ACTIVE+H_BLANK-1.
  - line_cnt: 0..V_SYNC_LINES+V_ACTIVE-1.
- States:
  - IDLE: VS=1, HS=0, D held. On a fall tick with i_Enable=1 → VSYNC, with pix_cnt=line_cnt=0 and address=0.
  - VSYNC: VS=1, HS=0 for V_SYNC_LINES full line periods. Then → LINE_BLANK with VS=0.
  - LINE_BLANK: VS=0, HS=0 for H_BLANK pixel periods. Then → LINE_ACTIVE.
  - LINE_ACTIVE: VS=0, HS=1 for H_ACTIVE pixel periods.
    - At each fall tick: o_D ← i_RAM_Data, address ← address+1.
    - After the last pixel of a line that is not the final line: → LINE_BLANK.
    - After the last pixel of the final line: o_Frame_Done pulses; at the next fall tick → VSYNC if i_Enable=1, else IDLE.
- Data ordering:
  - Each frame starts with a line-blank period, so every line emits H_BLANK blank periods followed by H_ACTIVE valid pixels.
  - The RAM address leads output data by one pixel period, so read latency ≤ 2*CLK_DIV-1 is always met.
  - o_RAM_Adress is 0 entering the first active pixel and ends at H_ACTIVE*V_ACTIVE after the frame; it is reset to 0 on entry to VSYNC.
  - o_D holds its last value while HS=0.
- i_Enable deassertion:
  - Mid-frame: the current frame completes unchanged, then → IDLE.
  - Reasserted during the final line: streaming continues seamlessly.
- Asynchronous reset mid-frame: immediate return to reset values. VS=1 makes a downstream receiver discard the partial frame.
- Frame length = (V_SYNC_LINES+V_ACTIVE)*(H_ACTIVE+H_BLANK)*2*CLK_DIV i_Clk cycles. With defaults: 98*104*4 = 40768 cycles.

Optional Feature:
- TEST_PATTERN_EN defined:
  - i_Pattern_Sel port exists. While high, o_D in LINE_ACTIVE = (active_pixel_index + active_line_index) mod 256.
  - RAM addressing is unchanged; i_RAM_Data is ignored.
  - i_Pattern_Sel is sampled only at line start, so it never changes mid-line.
- Undefined: no i_Pattern_Sel port; o_D always comes from RAM.

Test Plan:
- Reset release with i_Enable=0 → o_VS=1, o_HS=0, o_RAM_Adress=0, o_PCLK toggles every 2 i_Clk; no HS activity for 1000 cycles.
- RAM model returns data=addr[7:0]; i_Enable=1 for one frame → exactly 96 HS-high lines of 96 samples; byte n sampled at PCLK rise = n mod 256; o_Frame_Done pulses once; final address 9216.
- Continuous i_Enable=1 → o_Frame_Done pulses are exactly 40768 cycles apart; VS high for exactly 2*104*4 = 832 cycles per frame.
- i_Enable dropped at line 40 → frame completes through line 95 and o_Frame_Done fires; then IDLE with VS=1 and no further HS.
- i_Rst_n asserted at line 50, pixel 30 → within the same cycle VS=1, HS=0, D=0, address=0; after release with i_Enable=1 a full 9216-pixel frame is emitted.
- TEST_PATTERN_EN, i_Pattern_Sel=1 → line 3 pixel 5 carries 8; line 255 pixel 10 carries 9 (mod 256, V_ACTIVE=256 run).
